// File: rtl/eth_mac_conf_ctrl.sv
// eth_mac_conf_ctrl
//   Runtime-programmable source for the 10G MAC TX/RX configuration vectors.
//   Software fills shadow registers and pulses cfg_commit. The block then waits
//   until neither user stream is mid-frame, holds both MAC enables low for
//   QUIESCE_CYCLES cycles, and finally loads the shadow contents into both
//   vectors in the same cycle.
//
// Ports
//   clk156, sys_rst_n              : MAC clock, asynchronous active-low reset
//   cfg_wr_en/cfg_addr/cfg_wr_data : shadow register write port
//   cfg_commit                     : one-cycle apply request (ignored while busy)
//   cfg_busy, cfg_err              : commit in progress / last commit timed out
//   commit_count                   : successful applies, wraps at 16 bits
//   tx_axis_*, rx_axis_*           : MAC user streams, monitored for frame boundaries
//   mac_tx/rx_configuration_vector : registered vectors to the MAC
module eth_mac_conf_ctrl #(
    parameter logic [47:0] SRC_MAC        = 48'h001122334455,
    parameter int unsigned MAX_FRAME      = 1518,
    parameter int unsigned QUIESCE_CYCLES = 16,
    parameter int unsigned TIMEOUT        = 65535
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        cfg_wr_en,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wr_data,
    input  logic        cfg_commit,
    output logic        cfg_busy,
    output logic        cfg_err,
    output logic [15:0] commit_count,
    input  logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    input  logic        tx_axis_tlast,
    input  logic        rx_axis_tvalid,
    input  logic        rx_axis_tlast,
    output logic [79:0] mac_tx_configuration_vector,
    output logic [79:0] mac_rx_configuration_vector
);

    localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned QW  = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
    localparam logic [ToW-1:0] ToLast      = ToW'(TIMEOUT - 1);
    localparam logic [QW-1:0]  QLast       = QW'(QUIESCE_CYCLES - 1);
    localparam logic [14:0]    MaxFrameRst = 15'(MAX_FRAME);
    // {tx_dic, rx_lt_chk_dis, rx_len_chk_dis, jumbo, vlan, rx_en, tx_en}
    localparam logic [6:0]     FlagsRst    = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StWaitIdle, StHold, StApply} state_e;

    // Builds one MAC configuration vector from configuration fields.
    function automatic logic [79:0] mk_vec(input logic [47:0] mac, input logic [14:0] mf,
                                           input logic [6:0] flags, input logic is_tx);
        logic [79:0] v;
        v        = '0;
        v[79:32] = mac;
        v[30:16] = mf;
        v[4]     = flags[3];
        v[2]     = flags[2];
        if (is_tx) begin
            v[10] = flags[6];
            v[1]  = flags[0];
        end else begin
            v[9]  = flags[4];
            v[8]  = flags[5];
            v[1]  = flags[1];
        end
        return v;
    endfunction

    logic [47:0]    sh_mac_q;
    logic [14:0]    sh_mf_q;
    logic [6:0]     sh_flags_q;
    logic           tx_in_frame_q, rx_in_frame_q;
    state_e         state_q;
    logic [ToW-1:0] to_cnt_q;
    logic [QW-1:0]  hold_cnt_q;
    logic           busy_q, err_q;
    logic [15:0]    count_q;
    logic [79:0]    tx_vec_q, rx_vec_q;

    // Shadow registers: writable in any state, only read in StApply.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_mac_q   <= SRC_MAC;
            sh_mf_q    <= MaxFrameRst;
            sh_flags_q <= FlagsRst;
        end else if (cfg_wr_en) begin
            unique case (cfg_addr)
                2'd0: sh_mac_q[31:0]  <= cfg_wr_data;
                2'd1: sh_mac_q[47:32] <= cfg_wr_data[15:0];
                2'd2: sh_mf_q         <= cfg_wr_data[14:0];
                2'd3: sh_flags_q      <= cfg_wr_data[6:0];
            endcase
        end
    end

    // Frame trackers; a single-beat frame leaves the tracker clear.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_in_frame_q <= 1'b0;
            rx_in_frame_q <= 1'b0;
        end else begin
            if (tx_axis_tvalid && tx_axis_tready) tx_in_frame_q <= !tx_axis_tlast;
            if (rx_axis_tvalid)                   rx_in_frame_q <= !rx_axis_tlast;
        end
    end

    // Commit FSM with registered outputs.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            to_cnt_q   <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            tx_vec_q   <= mk_vec(SRC_MAC, MaxFrameRst, FlagsRst, 1'b1);
            rx_vec_q   <= mk_vec(SRC_MAC, MaxFrameRst, FlagsRst, 1'b0);
        end else begin
            case (state_q)
                StIdle: begin
                    if (cfg_commit) begin
                        state_q  <= StWaitIdle;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        to_cnt_q <= '0;
                    end
                end
                StWaitIdle: begin
                    if (!tx_in_frame_q && !rx_in_frame_q) begin
                        state_q     <= StHold;
                        hold_cnt_q  <= '0;
                        // Quiesce: drop only the enables, old config otherwise kept.
                        tx_vec_q[1] <= 1'b0;
                        rx_vec_q[1] <= 1'b0;
                    end else if (to_cnt_q == ToLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == QLast) state_q <= StApply;
                    else                     hold_cnt_q <= hold_cnt_q + 1'b1;
                end
                StApply: begin
                    tx_vec_q <= mk_vec(sh_mac_q, sh_mf_q, sh_flags_q, 1'b1);
                    rx_vec_q <= mk_vec(sh_mac_q, sh_mf_q, sh_flags_q, 1'b0);
                    count_q  <= count_q + 16'd1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_busy                    = busy_q;
    assign cfg_err                     = err_q;
    assign commit_count                = count_q;
    assign mac_tx_configuration_vector = tx_vec_q;
    assign mac_rx_configuration_vector = rx_vec_q;

endmodule

// File: tb/tb_eth_mac_conf_ctrl.sv
// Testbench for eth_mac_conf_ctrl: directed scenarios plus randomized shadow
// programming, checked against a field-level reference model.
module tb_eth_mac_conf_ctrl;

    localparam int unsigned Q  = 16;
    localparam int unsigned TO = 100;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wr_data;
    logic        cfg_commit;
    logic        cfg_busy;
    logic        cfg_err;
    logic [15:0] commit_count;
    logic        tx_axis_tvalid, tx_axis_tready, tx_axis_tlast;
    logic        rx_axis_tvalid, rx_axis_tlast;
    logic [79:0] tx_vec, rx_vec;

    eth_mac_conf_ctrl #(
        .SRC_MAC        (48'h001122334455),
        .MAX_FRAME      (1518),
        .QUIESCE_CYCLES (Q),
        .TIMEOUT        (TO)
    ) dut (
        .clk156                      (clk156),
        .sys_rst_n                   (sys_rst_n),
        .cfg_wr_en                   (cfg_wr_en),
        .cfg_addr                    (cfg_addr),
        .cfg_wr_data                 (cfg_wr_data),
        .cfg_commit                  (cfg_commit),
        .cfg_busy                    (cfg_busy),
        .cfg_err                     (cfg_err),
        .commit_count                (commit_count),
        .tx_axis_tvalid              (tx_axis_tvalid),
        .tx_axis_tready              (tx_axis_tready),
        .tx_axis_tlast               (tx_axis_tlast),
        .rx_axis_tvalid              (rx_axis_tvalid),
        .rx_axis_tlast               (rx_axis_tlast),
        .mac_tx_configuration_vector (tx_vec),
        .mac_rx_configuration_vector (rx_vec)
    );

    always #5 clk156 = ~clk156;

    typedef struct {
        logic [47:0] mac;
        int unsigned mf;
        bit tx_en, rx_en, vlan, jumbo, len_dis, lt_dis, dic;
    } cfg_t;

    cfg_t        sh, act;
    int unsigned cnt_m;
    bit          err_m;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic cfg_t reset_cfg();
        cfg_t c;
        c.mac = 48'h001122334455; c.mf = 1518;
        c.tx_en = 1; c.rx_en = 1; c.vlan = 1; c.jumbo = 1;
        c.len_dis = 1; c.lt_dis = 1; c.dic = 0;
        return c;
    endfunction

    // Expected vector from the field layout; kill models the quiesce window.
    function automatic logic [79:0] exp_vec(cfg_t c, bit tx, bit kill);
        int unsigned low;
        low = 0;
        if (c.jumbo) low += 16;
        if (c.vlan)  low += 4;
        if (tx) begin
            if (c.tx_en && !kill) low += 2;
            if (c.dic)            low += 1024;
        end else begin
            if (c.rx_en && !kill) low += 2;
            if (c.len_dis)        low += 512;
            if (c.lt_dis)         low += 256;
        end
        return {c.mac, 1'b0, 15'(c.mf), 16'(low)};
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: sh.mac[31:0]  = d;
            2'd1: sh.mac[47:32] = d[15:0];
            2'd2: sh.mf         = d % 32768;
            default: begin
                sh.tx_en = d[0]; sh.rx_en = d[1]; sh.vlan = d[2]; sh.jumbo = d[3];
                sh.len_dis = d[4]; sh.lt_dis = d[5]; sh.dic = d[6];
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit kill, input bit busy_e);
        chk({tag, ".tx"},    tx_vec, exp_vec(act, 1, kill));
        chk({tag, ".rx"},    rx_vec, exp_vec(act, 0, kill));
        chk({tag, ".busy"},  {79'b0, cfg_busy}, {79'b0, busy_e});
        chk({tag, ".err"},   {79'b0, cfg_err}, {79'b0, err_m});
        chk({tag, ".count"}, {64'b0, commit_count}, {64'b0, 16'(cnt_m)});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wr_en = 1; cfg_addr = a; cfg_wr_data = d;
        model_write(a, d);
        tick();
        cfg_wr_en = 0;
    endtask

    // Pulses cfg_commit (optionally with a same-cycle write); returns just after edge C.
    task automatic commit_start(input bit w, input logic [1:0] a, input logic [31:0] d);
        cfg_commit = 1;
        if (w) begin
            cfg_wr_en = 1; cfg_addr = a; cfg_wr_data = d;
            model_write(a, d);
        end
        tick();
        cfg_commit = 0; cfg_wr_en = 0;
        err_m = 0;
        check_state("commit", 0, 1);
    endtask

    // Entered just after the edge that starts the quiesce window. At step inj a
    // second commit plus an addr3 write of 0 is driven.
    task automatic hold_phase(input int inj);
        for (int k = 0; k <= int'(Q); k++) begin
            check_state("hold", 1, 1);
            if (k == inj) begin
                cfg_commit = 1; cfg_wr_en = 1; cfg_addr = 2'd3; cfg_wr_data = 32'h0;
                model_write(2'd3, 32'h0);
            end
            tick();
            cfg_commit = 0; cfg_wr_en = 0;
        end
        act   = sh;
        cnt_m = (cnt_m + 1) % 65536;
        check_state("apply", 0, 0);
    endtask

    task automatic commit_idle(input int inj);
        commit_start(0, 2'd0, 32'h0);
        tick();
        hold_phase(inj);
    endtask

    initial begin
        sys_rst_n = 0; cfg_wr_en = 0; cfg_addr = 0; cfg_wr_data = 0; cfg_commit = 0;
        tx_axis_tvalid = 0; tx_axis_tready = 0; tx_axis_tlast = 0;
        rx_axis_tvalid = 0; rx_axis_tlast = 0;
        sh = reset_cfg(); act = sh; cnt_m = 0; err_m = 0;

        // Reset values
        #12 sys_rst_n = 1;
        tick();
        chk("rst.tx_const", tx_vec, {48'h001122334455, 1'b0, 15'd1518, 16'h0016});
        chk("rst.rx_const", rx_vec, {48'h001122334455, 1'b0, 15'd1518, 16'h0316});
        check_state("rst", 0, 0);

        // Basic program and apply on an idle bus
        wr(2'd0, 32'hDEADBEEF);
        wr(2'd1, 32'h0000CAFE);
        wr(2'd2, 32'd9000);
        commit_idle(-1);
        chk("basic.mac", {32'b0, tx_vec[79:32]}, {32'b0, 48'hCAFEDEADBEEF});
        chk("basic.mf",  {65'b0, rx_vec[30:16]}, {65'b0, 15'd9000});
        chk("basic.en",  {78'b0, tx_vec[1], rx_vec[1]}, {78'b0, 2'b11});

        // TX frame in flight delays the quiesce until the tlast beat
        wr(2'd2, 32'd1500);
        tx_axis_tvalid = 1; tx_axis_tready = 1; tx_axis_tlast = 0;
        tick();
        tx_axis_tvalid = 0;
        commit_start(0, 2'd0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                // tlast without tready must not close the frame
                tx_axis_tvalid = 1; tx_axis_tlast = 1; tx_axis_tready = 0;
            end
            tick();
            tx_axis_tvalid = 0; tx_axis_tlast = 0; tx_axis_tready = 1;
            check_state("wait_tx", 0, 1);
        end
        tx_axis_tvalid = 1; tx_axis_tready = 1; tx_axis_tlast = 1;
        tick();
        tx_axis_tvalid = 0; tx_axis_tlast = 0;
        check_state("tlast", 0, 1);
        tick();
        hold_phase(-1);

        // RX frame never ends: commit times out
        rx_axis_tvalid = 1; rx_axis_tlast = 0;
        tick();
        rx_axis_tvalid = 0;
        wr(2'd0, $urandom);
        commit_start(0, 2'd0, 32'h0);
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            check_state("to_wait", 0, 1);
        end
        tick();
        err_m = 1;
        check_state("timeout", 0, 0);
        rx_axis_tvalid = 1; rx_axis_tlast = 1;
        tick();
        rx_axis_tvalid = 0; rx_axis_tlast = 0;
        commit_idle(-1);

        // Second commit during quiesce is dropped; same-cycle flag write applies
        commit_idle(3);
        chk("dbl.tx_low", {64'b0, tx_vec[15:0]}, 80'h0);
        chk("dbl.rx_low", {64'b0, rx_vec[15:0]}, 80'h0);
        repeat (25) tick();
        check_state("no_requeue", 0, 0);

        // Randomized programming, some writes coinciding with the commit
        for (int it = 0; it < 8; it++) begin
            int unsigned nw;
            nw = $urandom_range(1, 4);
            for (int j = 0; j < int'(nw); j++) wr(2'($urandom_range(0, 3)), $urandom);
            commit_start(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            tick();
            hold_phase(-1);
        end

        // Asynchronous reset in the middle of the quiesce window
        wr(2'd2, 32'd2000);
        commit_start(0, 2'd0, 32'h0);
        tick();
        tick();
        tick();
        #2 sys_rst_n = 0;
        #1;
        sh = reset_cfg(); act = sh; cnt_m = 0; err_m = 0;
        check_state("async_rst", 0, 0);
        #2 sys_rst_n = 1;
        tick();
        check_state("post_rst", 0, 0);
        commit_idle(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_mac_conf_ctrl.md
Name: eth_mac_conf_ctrl

Overview:
- Runtime-programmable source for the 10G MAC TX/RX configuration vectors.
- Sits directly upstream of the MAC and drives its mac_tx/rx_configuration_vector inputs.
- Software writes shadow registers, then commits them.
- On commit, the block waits for frame boundaries on the MAC user AXIS ports, briefly disables TX/RX, then applies the new configuration atomically to both vectors.

Parameters:
- SRC_MAC, 48'h001122334455, reset MAC address.
- MAX_FRAME, 1518, reset max frame length (15 bits used).
- QUIESCE_CYCLES, 16, cycles TX/RX enables are held low before apply (≥1).
- TIMEOUT, 65535, WAIT_IDLE cycle limit before the commit is aborted.

Ports:
- clk156  in  1  156.25 MHz MAC clock.
- sys_rst_n  in  1  reset.
- cfg_wr_en  in  1  shadow register write strobe.
- cfg_addr  in  2  shadow register select.
- cfg_wr_data  in  32  write data.
- cfg_commit  in  1  one-cycle pulse requesting apply.
- cfg_busy  out  1  commit in progress.
- cfg_err  out  1  sticky: last commit aborted by timeout.
- commit_count  out  16  number of successful applies, wraps.
- tx_axis_tvalid / tx_axis_tready / tx_axis_tlast  in  1 each  MAC TX user stream (monitor only).
- rx_axis_tvalid / rx_axis_tlast  in  1 each  MAC RX user stream (monitor only).
- mac_tx_configuration_vector  out  80  to MAC.
- mac_rx_configuration_vector  out  80  to MAC.

Behaviour:
- Single clock clk156; sys_rst_n is asynchronous, active-low.
- Shadow map:
  - addr0 = MAC[31:0].
  - addr1 = MAC[47:32] in bits 15:0.
  - addr2 = max frame in bits 14:0.
  - addr3 flags: b0 tx_en, b1 rx_en, b2 vlan, b3 jumbo, b4 rx_len_chk_dis, b5 rx_lt_chk_dis, b6 tx_dic.
  - Unused write bits are ignored.
- Vector layout, identical for TX and RX unless noted:
  - [79:32] MAC; [30:16] max frame; [10] DIC (TX only, RX=0).
  - [9] RX frame-length check disable (TX=0); [8] RX length/type check disable (TX=0).
  - [4] jumbo; [2] VLAN; [1] enable (tx_en / rx_en).
  - All other bits 0.
- Reset values, shadow and active:
  - MAC = SRC_MAC, max frame = MAX_FRAME.
  - tx_en=1, rx_en=1, vlan=1, jumbo=1, rx_len_chk_dis=1, rx_lt_chk_dis=1, tx_dic=0.
  - Resulting TX[15:0]=16'h0016, RX[15:0]=16'h0316.
  - cfg_busy=0, cfg_err=0, commit_count=0, state IDLE, frame trackers clear.
- Frame trackers:
  - tx_in_frame sets on tvalid&tready&!tlast and clears on tvalid&tready&tlast.
  - rx_in_frame uses tvalid only.
  - Single-beat frames never set a tracker.
- Shadow writes are accepted in any state. A write and commit in the same cycle: the write is included. Shadow contents are sampled only in APPLY.
- FSM IDLE→WAIT_IDLE→HOLD→APPLY→IDLE. All outputs are registered.
  - IDLE: cfg_commit → WAIT_IDLE; cfg_err cleared on that edge.
  - WAIT_IDLE: both trackers clear → HOLD. Timeout counter reaching TIMEOUT → IDLE, cfg_err=1, active config unchanged.
  - HOLD: bit1 forced 0 on both vectors, all other fields still old. Stays exactly QUIESCE_CYCLES cycles.
  - APPLY: one cycle; active ← shadow; commit_count+1 (wraps 16'hFFFF→0); → IDLE.
- Timing, commit sampled at edge C with no frame in flight:
  - cfg_busy=1 for cycles C+1..C+2+Q (Q = QUIESCE_CYCLES).
  - Enables 0 on outputs C+2..C+2+Q.
  - New vectors visible at C+3+Q.
- cfg_commit while busy is ignored (not queued).
- Reset mid-operation returns everything to reset values immediately (async); the pending commit is lost.

Test Plan:
- Reset: release sys_rst_n, no stimulus → TX vector = {48'h001122334455,1'b0,15'd1518,16'h0016}, RX = same with 16'h0316, cfg_busy=0, commit_count=0.
- Write addr0=32'hDEADBEEF, addr1=16'hCAFE, addr2=9000, commit at C, idle bus → bit1=0 on both at C+2..C+18; at C+19 MAC=48'hCAFEDEADBEEF, [30:16]=9000, bit1=1; commit_count=1.
- TX frame mid-packet (tvalid&tready, tlast=0) when commit → cfg_busy=1, enables stay 1 until tlast beat accepted; HOLD starts two cycles after tlast beat.
- TIMEOUT=100, rx_in_frame held with no tlast → at C+101 cfg_busy=0, cfg_err=1, vectors unchanged, commit_count unchanged; next commit clears cfg_err.
- Second cfg_commit during HOLD plus addr3 write of 0 → single apply only; written flags (tx_en=0, rx_en=0) take effect, TX/RX [15:0]=0; commit_count increments by 1.
- Assert sys_rst_n low during HOLD → vectors return to reset values and cfg_busy=0 without a clock edge.
